index_register_bus_master: RTL and testbench
============================================

Name: index_register_bus_master

Overview:
- Initiator side of the 4004 index-register bus. It converts single/pair read and write commands into the select / IO / write-enable / shared 4-bit data_bus sequence that the 16x4 index register file responds to.
- Sits between the 4004 execution control (FIM, SRC, FIN, XCH, INC, ISZ) and the index register file.
- Owns bus direction and turnaround, so the master and the register file never both drive data_bus.

Parameters:
DATA_W, 4, nibble width of data_bus and of each register
ADDR_W, 4, register select width (16 registers)
TURNAROUND, 1, idle cycles (IO=10) after a read before the bus may be reused; legal range 1..3

Ports:
clk  input  1  rising-edge clock
reset  input  1  reset, synchronous, active-low
cmd_valid  input  1  command request
cmd_ready  output  1  master can accept a command this cycle
cmd_op  input  2  00 read single, 01 write single, 10 read pair, 11 write pair
cmd_addr  input  ADDR_W  register index; bit0 ignored for pair ops
cmd_wdata  input  2*DATA_W  write data; [3:0] used for single, [7:4] even/high and [3:0] odd/low for pair
rsp_valid  output  1  one-cycle completion pulse, every op
rsp_rdata  output  2*DATA_W  read result; single read zero-extends into [3:0]
busy  output  1  high whenever state is not IDLE
index_register_select  output  ADDR_W  register select to the file
index_register_IO  output  2  00 write, 01 read (file drives bus), 10 idle
index_register_I_WE  output  1  write strobe, valid only with IO=00
data_bus  inout  DATA_W  shared tri-state nibble bus

Behaviour:
- Reset: reset==0 at a clk edge forces the following:
  - state=IDLE, IO=10, I_WE=0, select=0, data_bus released (Z).
  - rsp_valid=0, rsp_rdata=0, busy=0.
  - cmd_ready=0 combinationally while reset==0.
  - Reset mid-op aborts the op with no rsp_valid; the next cycle shows idle outputs.
- Handshake:
  - cmd_ready=1 only in IDLE with reset==1.
  - A command is accepted on a rising edge with cmd_valid&&cmd_ready; op, addr and wdata are registered at that edge.
  - Inputs are ignored when not accepted; no queuing.
- FSM states: IDLE, WR_A, WR_B, RD_SET_A, RD_CAP_A, RD_SET_B, RD_CAP_B, TURN, RESP.
- Pair addressing: first access uses {addr[3:1],0} (high nibble), second uses {addr[3:1],1} (low nibble). Single ops use addr as-is and take the _A states only.
- Write single: IDLE -> WR_A -> RESP -> IDLE.
- Write pair: IDLE -> WR_A -> WR_B -> RESP -> IDLE.
  - In WR_x: IO=00, I_WE=1, master drives data_bus with the nibble.
- Read single: IDLE -> RD_SET_A -> RD_CAP_A -> TURN -> RESP -> IDLE.
- Read pair: the read-single sequence with RD_SET_B/RD_CAP_B inserted after RD_CAP_A.
  - In RD_SET/RD_CAP: IO=01, I_WE=0, master data_bus=Z, select held across both cycles.
  - data_bus is sampled at the rising edge that ends RD_CAP_x.
- TURN: lasts exactly TURNAROUND cycles with IO=10, I_WE=0, bus Z. A down-counter sized for max 3 sets the length.
- RESP: one cycle, rsp_valid=1, IO=10, bus Z.
  - rsp_rdata updates only on read completion and holds until the next read completes.
  - Writes leave rsp_rdata unchanged.
- Latency from acceptance edge to the rsp_valid cycle:
  - write single 2, write pair 3.
  - read single 3+TURNAROUND, read pair 5+TURNAROUND.
  - cmd_ready returns the cycle after RESP.
- Bus rules (invariants):
  - Master drives data_bus only in WR_x, and only when IO=00.
  - IO=01 never coexists with master drive.
  - Every IO 01->00 transition is separated by ≥TURNAROUND cycles of IO=10.
  - A write-to-read transition needs no turnaround, because RESP already gives an IO=10 cycle.
- Outputs are registered except cmd_ready, busy and the data_bus tri-state enable, which decode the current state.

Test Plan:
- Reset defaults: after reset, read pair addr 0 -> rsp_rdata=8'h2C; read single addr 15 -> 8'h0F; rsp_valid at accept+4 with TURNAROUND=1.
- Write/read single: write addr 3 data 4'hA -> rsp_valid at accept+2; read addr 3 -> rsp_rdata=8'h0A; WE high exactly one cycle with IO=00, select=3.
- Pair with odd address: write pair addr 5 data 8'h7E -> reg4=7, reg5=E; read pair addr 4 -> 8'h7E; read single addr 5 -> 8'h0E.
- Back-to-back: cmd_valid held high with read-then-write -> second command accepted only the cycle after RESP. Monitor confirms no cycle where master drives while IO=01, and ≥TURNAROUND IO=10 cycles before WR_A; repeat with TURNAROUND=3.
- Reset mid-op: drop reset during RD_CAP_A of a read pair -> next cycle IO=10, bus Z, rsp_valid never pulses, cmd_ready=0 while reset low. After release, a read of addr 9 returns 8'h0F.
- Idle hold: no commands for 20 cycles -> IO=10, I_WE=0, data_bus Z, rsp_rdata unchanged, busy=0.

Source files
------------

// File: rtl/index_register_bus_master.sv
// Initiator for the 4004 index-register bus: turns single/pair read/write commands
// into select / IO / I_WE / data_bus sequences, owning bus direction and turnaround.
module index_register_bus_master #(
  parameter int DATA_W     = 4,
  parameter int ADDR_W     = 4,
  parameter int TURNAROUND = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [2*DATA_W-1:0]   cmd_wdata,
  output logic                  rsp_valid,
  output logic [2*DATA_W-1:0]   rsp_rdata,
  output logic                  busy,
  output logic [ADDR_W-1:0]     index_register_select,
  output logic [1:0]            index_register_IO,
  output logic                  index_register_I_WE,
  inout  wire  [DATA_W-1:0]     data_bus
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WR_A     = 4'd1,
    WR_B     = 4'd2,
    RD_SET_A = 4'd3,
    RD_CAP_A = 4'd4,
    RD_SET_B = 4'd5,
    RD_CAP_B = 4'd6,
    TURN     = 4'd7,
    RESP     = 4'd8
  } state_t;

  localparam logic [1:0] IO_WRITE  = 2'b00;
  localparam logic [1:0] IO_READ   = 2'b01;
  localparam logic [1:0] IO_IDLE   = 2'b10;
  localparam logic [1:0] TURN_LOAD = 2'(TURNAROUND - 1);

  state_t                state_r, state_next_s;
  logic [1:0]            op_r;
  logic [ADDR_W-1:0]     addr_r;
  logic [2*DATA_W-1:0]   wdata_r;
  logic [2*DATA_W-1:0]   cap_r;
  logic [1:0]            turn_cnt_r;
  logic [1:0]            io_r, io_next_s;
  logic                  we_r, we_next_s;
  logic [ADDR_W-1:0]     select_r, select_next_s;
  logic                  rsp_valid_r;
  logic [2*DATA_W-1:0]   rsp_rdata_r;
  logic                  accept_s;
  logic [1:0]            eff_op_s;
  logic [ADDR_W-1:0]     eff_addr_s;
  logic [ADDR_W-1:0]     sel_a_s, sel_b_s;
  logic                  drive_en_s;
  logic [DATA_W-1:0]     wr_nibble_s;

  assign cmd_ready = (state_r == IDLE) && reset;
  assign busy      = (state_r != IDLE);
  assign accept_s  = cmd_valid && cmd_ready;

  assign rsp_valid             = rsp_valid_r;
  assign rsp_rdata             = rsp_rdata_r;
  assign index_register_IO     = io_r;
  assign index_register_I_WE   = we_r;
  assign index_register_select = select_r;

  // Master drives the bus only while in a write state.
  assign drive_en_s = (state_r == WR_A) || (state_r == WR_B);
  assign data_bus   = drive_en_s ? wr_nibble_s : {DATA_W{1'bz}};

  // Pick the nibble for the current write beat; the pair's first beat carries the high nibble.
  always_comb begin
    if ((state_r == WR_A) && op_r[1]) begin
      wr_nibble_s = wdata_r[2*DATA_W-1:DATA_W];
    end else begin
      wr_nibble_s = wdata_r[DATA_W-1:0];
    end
  end

  // Outputs are registered from the next state, so the command fields must bypass on accept.
  always_comb begin
    if (accept_s) begin
      eff_op_s   = cmd_op;
      eff_addr_s = cmd_addr;
    end else begin
      eff_op_s   = op_r;
      eff_addr_s = addr_r;
    end
    sel_b_s = {eff_addr_s[ADDR_W-1:1], 1'b1};
    if (eff_op_s[1]) begin
      sel_a_s = {eff_addr_s[ADDR_W-1:1], 1'b0};
    end else begin
      sel_a_s = eff_addr_s;
    end
  end

  // State register, command latch, read capture and turnaround counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= IDLE;
      op_r       <= 2'b00;
      addr_r     <= {ADDR_W{1'b0}};
      wdata_r    <= {(2*DATA_W){1'b0}};
      cap_r      <= {(2*DATA_W){1'b0}};
      turn_cnt_r <= 2'd0;
    end else begin
      state_r <= state_next_s;
      if (accept_s) begin
        op_r    <= cmd_op;
        addr_r  <= cmd_addr;
        wdata_r <= cmd_wdata;
      end
      case (state_r)
        RD_CAP_A: begin
          if (op_r[1]) begin
            cap_r[2*DATA_W-1:DATA_W] <= data_bus;
          end else begin
            cap_r <= {{DATA_W{1'b0}}, data_bus};
          end
        end
        RD_CAP_B: cap_r[DATA_W-1:0] <= data_bus;
        default:  cap_r <= cap_r;
      endcase
      if ((state_next_s == TURN) && (state_r != TURN)) begin
        turn_cnt_r <= TURN_LOAD;
      end else if ((state_r == TURN) && (turn_cnt_r != 2'd0)) begin
        turn_cnt_r <= turn_cnt_r - 2'd1;
      end else begin
        turn_cnt_r <= turn_cnt_r;
      end
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = cmd_op[0] ? WR_A : RD_SET_A;
        end else begin
          state_next_s = IDLE;
        end
      end
      WR_A:     state_next_s = op_r[1] ? WR_B : RESP;
      WR_B:     state_next_s = RESP;
      RD_SET_A: state_next_s = RD_CAP_A;
      RD_CAP_A: state_next_s = op_r[1] ? RD_SET_B : TURN;
      RD_SET_B: state_next_s = RD_CAP_B;
      RD_CAP_B: state_next_s = TURN;
      TURN:     state_next_s = (turn_cnt_r == 2'd0) ? RESP : TURN;
      RESP:     state_next_s = IDLE;
      default:  state_next_s = IDLE;
    endcase
  end

  // Bus control values for the state about to be entered.
  always_comb begin
    io_next_s     = IO_IDLE;
    we_next_s     = 1'b0;
    select_next_s = select_r;
    case (state_next_s)
      WR_A: begin
        io_next_s     = IO_WRITE;
        we_next_s     = 1'b1;
        select_next_s = sel_a_s;
      end
      WR_B: begin
        io_next_s     = IO_WRITE;
        we_next_s     = 1'b1;
        select_next_s = sel_b_s;
      end
      RD_SET_A, RD_CAP_A: begin
        io_next_s     = IO_READ;
        select_next_s = sel_a_s;
      end
      RD_SET_B, RD_CAP_B: begin
        io_next_s     = IO_READ;
        select_next_s = sel_b_s;
      end
      default: begin
        io_next_s     = IO_IDLE;
        we_next_s     = 1'b0;
        select_next_s = select_r;
      end
    endcase
  end

  // Registered bus outputs and response; read data publishes as the read enters RESP.
  always_ff @(posedge clk) begin
    if (!reset) begin
      io_r        <= IO_IDLE;
      we_r        <= 1'b0;
      select_r    <= {ADDR_W{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {(2*DATA_W){1'b0}};
    end else begin
      io_r        <= io_next_s;
      we_r        <= we_next_s;
      select_r    <= select_next_s;
      rsp_valid_r <= (state_next_s == RESP);
      if ((state_r == TURN) && (state_next_s == RESP)) begin
        rsp_rdata_r <= cap_r;
      end else begin
        rsp_rdata_r <= rsp_rdata_r;
      end
    end
  end

endmodule

// File: tb/tb_index_register_bus_master.sv
// Directed bench: two masters (TURNAROUND 1 and 3), each on its own modelled 16x4
// register file; the buses are pulled up so a released bus reads 4'hF.
module tb_index_register_bus_master;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance 1: TURNAROUND = 1
  logic       v1 = 1'b0, rdy1, rv1, busy1, we1;
  logic [1:0] op1 = 2'b00, io1;
  logic [3:0] ad1 = 4'h0, sel1;
  logic [7:0] wd1 = 8'h00, rd1;
  wire  [3:0] bus1;
  // Instance 3: TURNAROUND = 3
  logic       v3 = 1'b0, rdy3, rv3, busy3, we3;
  logic [1:0] op3 = 2'b00, io3;
  logic [3:0] ad3 = 4'h0, sel3;
  logic [7:0] wd3 = 8'h00, rd3;
  wire  [3:0] bus3;

  logic [3:0] mem1 [16] = '{4'h2, 4'hC, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF,
                            4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
  logic [3:0] mem3 [16] = '{4'h2, 4'hC, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF,
                            4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};

  pullup pu1 (bus1);
  pullup pu3 (bus3);
  assign bus1 = (io1 == 2'b01) ? mem1[sel1] : 4'bz;
  assign bus3 = (io3 == 2'b01) ? mem3[sel3] : 4'bz;

  always @(posedge clk) begin
    if (io1 == 2'b00 && we1) mem1[sel1] <= bus1;
    if (io3 == 2'b00 && we3) mem3[sel3] <= bus3;
  end

  index_register_bus_master #(.DATA_W(4), .ADDR_W(4), .TURNAROUND(1)) dut1 (
    .clk(clk), .reset(reset), .cmd_valid(v1), .cmd_ready(rdy1), .cmd_op(op1),
    .cmd_addr(ad1), .cmd_wdata(wd1), .rsp_valid(rv1), .rsp_rdata(rd1), .busy(busy1),
    .index_register_select(sel1), .index_register_IO(io1),
    .index_register_I_WE(we1), .data_bus(bus1));

  index_register_bus_master #(.DATA_W(4), .ADDR_W(4), .TURNAROUND(3)) dut3 (
    .clk(clk), .reset(reset), .cmd_valid(v3), .cmd_ready(rdy3), .cmd_op(op3),
    .cmd_addr(ad3), .cmd_wdata(wd3), .rsp_valid(rv3), .rsp_rdata(rd3), .busy(busy3),
    .index_register_select(sel3), .index_register_IO(io3),
    .index_register_I_WE(we3), .data_bus(bus3));

  // Bus-rule monitor: turnaround gap before a write, released bus when idle, WE only with IO=00.
  int run1 = 0, run3 = 0, vturn1 = 0, vturn3 = 0, vbus1 = 0, vbus3 = 0, vwe1 = 0, vwe3 = 0;
  bit seen1 = 1'b0, seen3 = 1'b0;
  always @(negedge clk) begin
    if (io1 == 2'b01) begin seen1 <= 1'b1; run1 <= 0; end
    else if (io1 == 2'b10) run1 <= run1 + 1;
    else begin if (seen1 && run1 < 1) vturn1 <= vturn1 + 1; seen1 <= 1'b0; end
    if (io3 == 2'b01) begin seen3 <= 1'b1; run3 <= 0; end
    else if (io3 == 2'b10) run3 <= run3 + 1;
    else begin if (seen3 && run3 < 3) vturn3 <= vturn3 + 1; seen3 <= 1'b0; end
    if (io1 == 2'b10 && bus1 !== 4'hF) vbus1 <= vbus1 + 1;
    if (io3 == 2'b10 && bus3 !== 4'hF) vbus3 <= vbus3 + 1;
    if (we1 && io1 != 2'b00) vwe1 <= vwe1 + 1;
    if (we3 && io3 != 2'b00) vwe3 <= vwe3 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command; lat counts cycles from the accept cycle (0) to the rsp_valid cycle.
  task automatic run_cmd(input int inst, input logic [1:0] op, input logic [3:0] addr,
                         input logic [7:0] wd, output int lat, output int we_cnt,
                         output logic [3:0] we_sel, output logic [1:0] we_io);
    lat = 0; we_cnt = 0; we_sel = 4'h0; we_io = 2'b11;
    @(negedge clk);
    if (inst == 1) begin v1 = 1'b1; op1 = op; ad1 = addr; wd1 = wd; end
    else begin v3 = 1'b1; op3 = op; ad3 = addr; wd3 = wd; end
    for (int k = 0; k < 20; k++) begin
      if ((inst == 1) ? rdy1 : rdy3) break;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    v1 = 1'b0; v3 = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if ((inst == 1) ? we1 : we3) begin
        we_cnt++;
        we_sel = (inst == 1) ? sel1 : sel3;
        we_io  = (inst == 1) ? io1 : io3;
      end
      if ((inst == 1) ? rv1 : rv3) begin lat = k; break; end
    end
  endtask

  // Read then write with cmd_valid held high throughout.
  task automatic b2b(input int inst, input logic [3:0] raddr, input logic [3:0] waddr,
                     input logic [7:0] wd, output int rsp_cyc, output int rdy_cyc,
                     output int wr_lat);
    rsp_cyc = 0; rdy_cyc = 0; wr_lat = 0;
    @(negedge clk);
    if (inst == 1) begin v1 = 1'b1; op1 = 2'b00; ad1 = raddr; end
    else begin v3 = 1'b1; op3 = 2'b00; ad3 = raddr; end
    @(posedge clk);
    #1;
    if (inst == 1) begin op1 = 2'b01; ad1 = waddr; wd1 = wd; end
    else begin op3 = 2'b01; ad3 = waddr; wd3 = wd; end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (((inst == 1) ? rv1 : rv3) && rsp_cyc == 0) rsp_cyc = k;
      if ((inst == 1) ? rdy1 : rdy3) begin rdy_cyc = k; break; end
    end
    @(posedge clk);
    #1;
    v1 = 1'b0; v3 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if ((inst == 1) ? rv1 : rv3) begin wr_lat = k; break; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, wec, c1, c2, c3, idle_bad, pulses;
    logic [3:0] wsel;
    logic [1:0] wio;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_io", io1, 2'b10);
    chk("rst_we", we1, 1'b0);
    chk("rst_sel", sel1, 4'h0);
    chk("rst_bus", bus1, 4'hF);
    chk("rst_rv", rv1, 1'b0);
    chk("rst_rdata", rd1, 8'h00);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_ready_low", rdy1, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", rdy1, 1'b1);

    // Reset-default contents
    run_cmd(1, 2'b10, 4'h0, 8'h00, lat, wec, wsel, wio);
    chk("rdpair0_lat", lat, 6);
    chk("rdpair0_data", rd1, 8'h2C);
    chk("rdpair0_busy_in_resp", busy1, 1'b1);
    run_cmd(1, 2'b00, 4'hF, 8'h00, lat, wec, wsel, wio);
    chk("rd15_lat", lat, 4);
    chk("rd15_data", rd1, 8'h0F);

    // Single write / read
    run_cmd(1, 2'b01, 4'h3, 8'h0A, lat, wec, wsel, wio);
    chk("wr3_lat", lat, 2);
    chk("wr3_we_cycles", wec, 1);
    chk("wr3_we_sel", wsel, 4'h3);
    chk("wr3_we_io", wio, 2'b00);
    chk("wr3_rdata_held", rd1, 8'h0F);
    chk("wr3_mem", mem1[3], 4'hA);
    run_cmd(1, 2'b00, 4'h3, 8'h00, lat, wec, wsel, wio);
    chk("rd3_data", rd1, 8'h0A);

    // Pair with odd address
    run_cmd(1, 2'b11, 4'h5, 8'h7E, lat, wec, wsel, wio);
    chk("wrpair5_lat", lat, 3);
    chk("wrpair5_we_cycles", wec, 2);
    chk("wrpair5_last_sel", wsel, 4'h5);
    chk("wrpair5_reg4", mem1[4], 4'h7);
    chk("wrpair5_reg5", mem1[5], 4'hE);
    run_cmd(1, 2'b10, 4'h4, 8'h00, lat, wec, wsel, wio);
    chk("rdpair4_data", rd1, 8'h7E);
    run_cmd(1, 2'b00, 4'h5, 8'h00, lat, wec, wsel, wio);
    chk("rd5_data", rd1, 8'h0E);

    // Back-to-back, TURNAROUND=1
    b2b(1, 4'h3, 4'h6, 8'h05, c1, c2, c3);
    chk("b2b1_rsp_cycle", c1, 4);
    chk("b2b1_ready_cycle", c2, 5);
    chk("b2b1_wr_lat", c3, 2);
    chk("b2b1_rdata", rd1, 8'h0A);
    chk("b2b1_mem6", mem1[6], 4'h5);

    // TURNAROUND=3 instance
    run_cmd(3, 2'b00, 4'h1, 8'h00, lat, wec, wsel, wio);
    chk("t3_rd1_lat", lat, 6);
    chk("t3_rd1_data", rd3, 8'h0C);
    run_cmd(3, 2'b10, 4'h0, 8'h00, lat, wec, wsel, wio);
    chk("t3_rdpair0_lat", lat, 8);
    chk("t3_rdpair0_data", rd3, 8'h2C);
    b2b(3, 4'h3, 4'h2, 8'h09, c1, c2, c3);
    chk("b2b3_rsp_cycle", c1, 6);
    chk("b2b3_ready_cycle", c2, 7);
    chk("b2b3_wr_lat", c3, 2);
    chk("b2b3_rdata", rd3, 8'h0F);
    chk("b2b3_mem2", mem3[2], 4'h9);

    // Idle hold
    idle_bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (io1 !== 2'b10 || we1 !== 1'b0 || bus1 !== 4'hF || rd1 !== 8'h0A || busy1 !== 1'b0)
        idle_bad++;
    end
    chk("idle_hold_bad_cycles", idle_bad, 0);
    chk("idle_rdata", rd1, 8'h0A);

    // Reset during RD_CAP_A of a read pair
    pulses = 0;
    @(negedge clk);
    v1 = 1'b1; op1 = 2'b10; ad1 = 4'h0;
    @(posedge clk);
    #1;
    v1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_in_read", io1, 2'b01);
    reset = 1'b0;
    @(negedge clk);
    if (rv1) pulses++;
    chk("midrst_io", io1, 2'b10);
    chk("midrst_bus", bus1, 4'hF);
    chk("midrst_busy", busy1, 1'b0);
    chk("midrst_ready_low", rdy1, 1'b0);
    @(negedge clk);
    if (rv1) pulses++;
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rv1) pulses++;
    end
    chk("midrst_no_rsp", pulses, 0);
    chk("midrst_rdata_cleared", rd1, 8'h00);
    run_cmd(1, 2'b00, 4'h9, 8'h00, lat, wec, wsel, wio);
    chk("postrst_rd9_lat", lat, 4);
    chk("postrst_rd9_data", rd1, 8'h0F);

    // Bus-rule monitor totals
    repeat (2) @(negedge clk);
    chk("mon_turn_t1", vturn1, 0);
    chk("mon_turn_t3", vturn3, 0);
    chk("mon_bus_t1", vbus1, 0);
    chk("mon_bus_t3", vbus3, 0);
    chk("mon_we_t1", vwe1, 0);
    chk("mon_we_t3", vwe3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
